// File: rtl/rect_fill.sv
// rect_fill: fills a rectangle of a framebuffer with one colour, one VRAM word per cycle.
// Optional feature macro: RECT_FILL_CLIP_EN (clip to FB_W x FB_H; default build writes unclipped, wrapping addresses).
// Ports: clk, reset (async, active-high);
//        cmd_valid/cmd_ready handshake with cmd_x, cmd_y, cmd_w, cmd_h, cmd_color;
//        vram_write_addr/vram_write_data/vram_write_en write port; busy, done status.
module rect_fill #(
    parameter int FB_W = 256,
    parameter int FB_H = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic [9:0]  cmd_w,
    input  logic [9:0]  cmd_h,
    input  logic [11:0] cmd_color,
    output logic [15:0] vram_write_addr,
    output logic [15:0] vram_write_data,
    output logic        vram_write_en,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;
    localparam logic [10:0] FBW11 = 11'(FB_W);
    localparam logic [10:0] FBH11 = 11'(FB_H);
    localparam logic [15:0] FBW16 = 16'(FB_W);
    state_t      state;
    logic [9:0]  x0, y0, w0, h0;
    logic [11:0] color;
    logic [10:0] x1, y1, cx, cy;
    logic [15:0] row_base;
    logic [10:0] sum_x, sum_y, ex, ey;
    logic [15:0] base0;
    logic        skip;
    assign sum_x = {1'b0, x0} + {1'b0, w0};
    assign sum_y = {1'b0, y0} + {1'b0, h0};
    // Start-row base is a constant-coefficient product (shift/add); later rows step by FB_W.
    assign base0 = {6'd0, y0} * FBW16;
`ifdef RECT_FILL_CLIP_EN
    assign ex   = sum_x > FBW11 ? FBW11 : sum_x;
    assign ey   = sum_y > FBH11 ? FBH11 : sum_y;
    assign skip = w0 == 10'd0 || h0 == 10'd0 || {1'b0, x0} >= FBW11 || {1'b0, y0} >= FBH11;
`else
    assign ex   = sum_x;
    assign ey   = sum_y;
    assign skip = w0 == 10'd0 || h0 == 10'd0;
`endif
    assign cmd_ready     = state == IDLE;
    assign busy          = state != IDLE;
    assign done          = state == DONE;
    assign vram_write_en = state == FILL;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            x0              <= '0;
            y0              <= '0;
            w0              <= '0;
            h0              <= '0;
            color           <= '0;
            x1              <= '0;
            y1              <= '0;
            cx              <= '0;
            cy              <= '0;
            row_base        <= '0;
            vram_write_addr <= '0;
            vram_write_data <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    x0    <= cmd_x;
                    y0    <= cmd_y;
                    w0    <= cmd_w;
                    h0    <= cmd_h;
                    color <= cmd_color;
                    state <= CLIP;
                end
                CLIP: begin
                    x1              <= ex;
                    y1              <= ey;
                    cx              <= {1'b0, x0};
                    cy              <= {1'b0, y0};
                    row_base        <= base0;
                    vram_write_addr <= base0 + {6'd0, x0};
                    vram_write_data <= {4'd0, color};
                    state           <= skip ? DONE : FILL;
                end
                FILL: begin
                    if (cx + 11'd1 != x1) begin
                        cx              <= cx + 11'd1;
                        vram_write_addr <= vram_write_addr + 16'd1;
                    end else if (cy + 11'd1 != y1) begin
                        cx              <= {1'b0, x0};
                        cy              <= cy + 11'd1;
                        row_base        <= row_base + FBW16;
                        vram_write_addr <= row_base + FBW16 + {6'd0, x0};
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rect_fill.sv
// tb_rect_fill: scoreboard bench for rect_fill; expected VRAM writes are queued per command and popped by a write monitor.
module tb_rect_fill;
    localparam int FB_W = 256;
    localparam int FB_H = 240;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [11:0] cmd_color = '0;
    logic [15:0] vram_write_addr, vram_write_data;
    logic        vram_write_en, busy, done;
    rect_fill #(.FB_W(FB_W), .FB_H(FB_H)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .vram_write_addr(vram_write_addr), .vram_write_data(vram_write_data),
        .vram_write_en(vram_write_en), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    int total = 0, bad = 0, cyc = 0;
    int n_wr = 0, n_done = 0, busy_cnt = 0, first_wr = 0, last_wr = 0, done_cyc = 0;
    logic [15:0] last_addr = '0;
    logic [31:0] sb[$];
    logic [31:0] e;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!reset) begin
        if (vram_write_en) begin
            if (n_wr == 0) first_wr = cyc;
            last_wr = cyc;
            last_addr = vram_write_addr;
            n_wr++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected got addr=%0d data=%h want no write", vram_write_addr, vram_write_data);
            end else begin
                e = sb.pop_front();
                if ({vram_write_addr, vram_write_data} !== e) begin
                    bad++;
                    $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                             vram_write_addr, vram_write_data, e[31:16], e[15:0]);
                end
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask
    task automatic push(input int a, input logic [11:0] c);
        sb.push_back({16'(a), 4'd0, c});
    endtask
    task automatic push_rect(input int x, input int y, input int w, input int h, input logic [11:0] c, output int n);
        int xe, ye;
        n = 0;
        xe = x + w;
        ye = y + h;
`ifdef RECT_FILL_CLIP_EN
        if (xe > FB_W) xe = FB_W;
        if (ye > FB_H) ye = FB_H;
        if (x >= FB_W || y >= FB_H) ye = y;
`endif
        for (int yy = y; yy < ye; yy++)
            for (int xx = x; xx < xe; xx++) begin
                push(yy * FB_W + xx, c);
                n++;
            end
    endtask
    task automatic issue(input int x, input int y, input int w, input int h, input logic [11:0] c,
                         input bit noise, output int acc);
        int k;
        n_wr = 0;
        n_done = 0;
        busy_cnt = 0;
        cmd_x = 10'(x);
        cmd_y = 10'(y);
        cmd_w = 10'(w);
        cmd_h = 10'(h);
        cmd_color = c;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        acc = cyc;
        if (!noise) cmd_valid = 1'b0;
    endtask
    task automatic finish(input int acc, input int exp_n, input bit noise);
        int k;
        k = 0;
        while (n_done == 0 && k < 500) begin
            if (noise) begin
                cmd_x = 10'($urandom_range(0, 1023));
                cmd_y = 10'($urandom_range(0, 1023));
                cmd_w = 10'($urandom_range(0, 1023));
                cmd_h = 10'($urandom_range(0, 1023));
                cmd_color = 12'($urandom);
            end
            @(posedge clk); #1;
            k++;
        end
        if (!noise) cmd_valid = 1'b0;
        check("done_pulses", n_done, 1);
        check("done_width", done, 0);
        check("write_count", n_wr, exp_n);
        if (exp_n > 0) begin
            check("first_write_latency", first_wr - acc, 1);
            check("done_after_last_write", done_cyc - last_wr, 1);
        end else begin
            check("done_latency", done_cyc - acc, 1);
        end
        check("busy_cycles", busy_cnt, exp_n + 2);
        check("scoreboard_empty", sb.size(), 0);
        sb.delete();
    endtask
    initial begin
        int acc, n, c0, d0, k;
        #12;
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", vram_write_en, 0);
        check("rst_addr", vram_write_addr, 0);
        check("rst_data", vram_write_data, 0);
        @(negedge clk);
        reset = 1'b0;
        c0 = cyc;
        push(770, 12'hF0A); push(771, 12'hF0A); push(772, 12'hF0A);
        push(1026, 12'hF0A); push(1027, 12'hF0A); push(1028, 12'hF0A);
        issue(2, 3, 3, 2, 12'hF0A, 1'b0, acc);
        check("accept_after_reset", acc - c0, 1);
        finish(acc, 6, 1'b0);
        push_rect(250, 238, 10, 10, 12'h0C3, n);
        issue(250, 238, 10, 10, 12'h0C3, 1'b0, acc);
        finish(acc, n, 1'b0);
`ifdef RECT_FILL_CLIP_EN
        check("clip_count", n, 12);
        check("clip_last_addr", last_addr, 61439);
`else
        check("noclip_last_addr", last_addr, 63491);
`endif
        push_rect(5, 5, 0, 4, 12'h111, n);
        issue(5, 5, 0, 4, 12'h111, 1'b0, acc);
        finish(acc, n, 1'b0);
        push_rect(7, 9, 3, 0, 12'h222, n);
        issue(7, 9, 3, 0, 12'h222, 1'b0, acc);
        finish(acc, n, 1'b0);
        push_rect(300, 0, 2, 1, 12'h333, n);
        issue(300, 0, 2, 1, 12'h333, 1'b0, acc);
        finish(acc, n, 1'b0);
        push_rect(5, 5, 4, 3, 12'h123, n);
        issue(5, 5, 4, 3, 12'h123, 1'b1, acc);
        finish(acc, n, 1'b1);
        d0 = done_cyc;
        push_rect(0, 0, 2, 2, 12'hABC, n);
        issue(0, 0, 2, 2, 12'hABC, 1'b1, acc);
        check("b2b_gap", acc - d0, 2);
        finish(acc, n, 1'b1);
        cmd_valid = 1'b0;
        push(2570, 12'h777); push(2571, 12'h777); push(2572, 12'h777);
        issue(10, 10, 4, 4, 12'h777, 1'b0, acc);
        k = 0;
        while (n_wr < 3 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        check("third_write_seen", n_wr, 3);
        reset = 1'b1;
        #1;
        check("abort_we", vram_write_en, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_addr", vram_write_addr, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", n_done, 0);
        check("abort_writes", n_wr, 3);
        check("abort_sb_empty", sb.size(), 0);
        push(257, 12'h555);
        issue(1, 1, 1, 1, 12'h555, 1'b0, acc);
        finish(acc, 1, 1'b0);
`ifdef RECT_FILL_CLIP_EN
        for (int i = 250; i < 256; i++) push(i, 12'h0F0);
        issue(250, 0, 10, 1, 12'h0F0, 1'b0, acc);
        finish(acc, 6, 1'b0);
`else
        for (int i = 250; i < 260; i++) push(i, 12'h0F0);
        issue(250, 0, 10, 1, 12'h0F0, 1'b0, acc);
        finish(acc, 10, 1'b0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
